// File: rtl/zvc_encoder_pkg.sv
// Shared constants, state type and popcount helper for the zero-value-compression encoder.
package zvc_pkg;
    localparam int BEAT_BYTES = 16;
    localparam int OUT_W      = 256;
    localparam int WORD_SIZE  = 128;
    localparam int BITMAP_W   = 16;
    localparam int MAX_CW     = 144;
    localparam int BEAT_W     = BEAT_BYTES * 8;

    typedef enum logic {RUN, PAD} state_e;

    function automatic logic [4:0] popcnt(input logic [BITMAP_W-1:0] m);
        logic [4:0] p;
        p = '0;
        for (int i = 0; i < BITMAP_W; i++) p = p + 5'(m[i]);
        return p;
    endfunction
endpackage

// File: rtl/zvc_encoder_if.sv
// Beat input / codeword output bundle between the encoder and its neighbours.
interface zvc_encoder_if;
    import zvc_pkg::*;
    logic [BEAT_W-1:0] i_beat;
    logic              i_valid;
    logic              i_last;
    logic              o_ready;
    logic [9:0]        i_space;
    logic [OUT_W-1:0]  o_data;
    logic [8:0]        o_data_size;
    logic              o_write_en;
    logic [31:0]       o_beat_count;
    logic [31:0]       o_bit_count;

    modport master (output i_beat, i_valid, i_last, i_space,
                    input  o_ready, o_data, o_data_size, o_write_en, o_beat_count, o_bit_count);
    modport slave  (input  i_beat, i_valid, i_last, i_space,
                    output o_ready, o_data, o_data_size, o_write_en, o_beat_count, o_bit_count);
endinterface

// File: rtl/zvc_encoder_compact.sv
// Combinational byte compactor: nonzero bytes of a beat packed toward the MSB in ascending byte order.
module zvc_compact
    import zvc_pkg::*;
(
    input  logic [BEAT_W-1:0]   beat_i,
    input  logic [BITMAP_W-1:0] bmp_i,
    output logic [BEAT_W-1:0]   packed_o
);
    // pre[k] = number of nonzero bytes below byte k = its output slot
    logic [BEAT_BYTES-1:0][4:0] pre;

    always_comb begin
        pre = '0;
        for (int k = 0; k < BEAT_BYTES; k++)
            for (int i = 0; i < k; i++)
                pre[k] = pre[k] + 5'(bmp_i[i]);
    end

    for (genvar j = 0; j < BEAT_BYTES; j++) begin : g_slot
        logic [7:0] slot;
        always_comb begin
            slot = '0;
            for (int k = 0; k < BEAT_BYTES; k++)
                if (bmp_i[k] && pre[k] == 5'(j)) slot = slot | beat_i[8*k +: 8];
        end
        assign packed_o[BEAT_W-1-8*j -: 8] = slot;
    end
endmodule

// File: rtl/zvc_encoder.sv
// ZVC encoder: beat -> {bitmap, nonzero bytes} codeword, plus a zero pad at tile end to reach a 128-bit boundary.
// Optional statistics counters are built when ZVC_STATS_EN is defined.
module zvc_encoder
    import zvc_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    zvc_encoder_if.slave  bus
);
    logic                s1_vld_q, s1_last_q;
    logic [BEAT_W-1:0]   s1_beat_q;
    logic [BITMAP_W-1:0] s1_bmp_q;
    logic [4:0]          s1_pop_q;
    logic                out_vld_q, out_last_q;
    logic [OUT_W-1:0]    out_data_q;
    logic [8:0]          out_size_q;
    state_e              state_q, state_d;
    logic [6:0]          bitpos_q, bitpos_d;
    logic                fire, go_pad, s1_adv, ready, accept;
    logic [BITMAP_W-1:0] in_bmp;
    logic [BEAT_W-1:0]   packed_bytes;

    always_comb begin
        in_bmp = '0;
        for (int k = 0; k < BEAT_BYTES; k++) in_bmp[k] = |bus.i_beat[8*k +: 8];
    end

    zvc_compact u_compact (.beat_i(s1_beat_q), .bmp_i(s1_bmp_q), .packed_o(packed_bytes));

    // Downstream cannot push back, so a codeword is only presented once it fits
    assign fire     = out_vld_q && ({1'b0, out_size_q} <= bus.i_space);
    assign bitpos_d = fire ? bitpos_q + out_size_q[6:0] : bitpos_q;

    always_comb begin
        state_d = state_q;
        go_pad  = 1'b0;
        case (state_q)
            RUN: if (fire && out_last_q && bitpos_d != 7'd0) begin
                state_d = PAD;
                go_pad  = 1'b1;
            end
            PAD: if (fire) state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    // The pad is loaded into OUT on the same edge that enters PAD, so S1 must hold
    assign s1_adv = s1_vld_q && state_q == RUN && !go_pad && (!out_vld_q || fire);
    assign ready  = state_q == RUN && (!s1_vld_q || s1_adv);
    assign accept = bus.i_valid && ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld_q   <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_beat_q  <= '0;
            s1_bmp_q   <= '0;
            s1_pop_q   <= '0;
            out_vld_q  <= 1'b0;
            out_last_q <= 1'b0;
            out_data_q <= '0;
            out_size_q <= '0;
            state_q    <= RUN;
            bitpos_q   <= '0;
        end else begin
            state_q  <= state_d;
            bitpos_q <= bitpos_d;
            if (accept) begin
                s1_vld_q  <= 1'b1;
                s1_last_q <= bus.i_last;
                s1_beat_q <= bus.i_beat;
                s1_bmp_q  <= in_bmp;
                s1_pop_q  <= popcnt(in_bmp);
            end else if (s1_adv) begin
                s1_vld_q <= 1'b0;
            end
            if (go_pad) begin
                out_vld_q  <= 1'b1;
                out_last_q <= 1'b0;
                out_data_q <= '0;
                out_size_q <= 9'(WORD_SIZE) - 9'(bitpos_d);
            end else if (s1_adv) begin
                out_vld_q  <= 1'b1;
                out_last_q <= s1_last_q;
                out_data_q <= {s1_bmp_q, packed_bytes, {(OUT_W-BITMAP_W-BEAT_W){1'b0}}};
                out_size_q <= 9'(BITMAP_W) + {1'b0, s1_pop_q, 3'b000};
            end else if (fire) begin
                out_vld_q <= 1'b0;
            end
        end
    end

    assign bus.o_ready     = ready;
    assign bus.o_data      = out_data_q;
    assign bus.o_data_size = out_size_q;
    assign bus.o_write_en  = fire;

`ifdef ZVC_STATS_EN
    logic [31:0] beat_cnt_q, bit_cnt_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_cnt_q <= '0;
            bit_cnt_q  <= '0;
        end else begin
            if (accept) beat_cnt_q <= beat_cnt_q + 32'd1;
            if (fire)   bit_cnt_q  <= bit_cnt_q + 32'(out_size_q);
        end
    end
    assign bus.o_beat_count = beat_cnt_q;
    assign bus.o_bit_count  = bit_cnt_q;
`else
    assign bus.o_beat_count = '0;
    assign bus.o_bit_count  = '0;
`endif
endmodule

// File: tb/tb_zvc_encoder.sv
// Self-checking bench for zvc_encoder: constant vector table, hand-written corner sequences, random beats vs a codeword model.
module tb_zvc_encoder;
    import zvc_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    zvc_encoder_if bus();
    zvc_encoder dut (.clk(clk), .rst(rst), .bus(bus));

    int n_cmp = 0, n_bad = 0;
    int cyc = 0;
    bit rnd = 1'b0;

    typedef struct { logic [255:0] d; logic [8:0] s; } cw_t;
    typedef struct { logic [255:0] d; logic [8:0] s; logic rdy; int cyc; } wr_t;
    typedef struct { logic [127:0] b; logic [8:0] s; logic [143:0] hi; } vec_t;

    cw_t exp_q[$];
    wr_t log_q[$];
    cw_t mon_e, mon_c, mon_p;
    int  acc = 0, m_beats = 0, m_bits = 0;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Codeword straight from the format rules: bitmap on top, nonzero bytes below in byte order
    function automatic cw_t encode(input logic [127:0] b);
        cw_t c;
        int n;
        c.d = '0;
        n = 0;
        for (int k = 0; k < 16; k++) begin
            if (b[8*k +: 8] != 8'h00) begin
                c.d[240+k] = 1'b1;
                c.d[239-8*n -: 8] = b[8*k +: 8];
                n++;
            end
        end
        c.s = 9'(16 + 8*n);
        return c;
    endfunction

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            acc = 0; m_beats = 0; m_bits = 0;
        end else begin
            if (bus.o_write_en) begin
                log_q.push_back('{bus.o_data, bus.o_data_size, bus.o_ready, cyc});
                m_bits += int'(bus.o_data_size);
                chk("wr_fits", 256'(bus.o_data_size <= bus.i_space), 256'd1);
                if (exp_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL wr_unexpected: got size %0d expected no write", bus.o_data_size);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("wr_size", 256'(bus.o_data_size), 256'(mon_e.s));
                    chk("wr_data", bus.o_data, mon_e.d);
                end
            end
            if (bus.i_valid && bus.o_ready) begin
                mon_c = encode(bus.i_beat);
                exp_q.push_back(mon_c);
                m_beats++;
                acc += int'(mon_c.s);
                if (bus.i_last) begin
                    if (acc % 128 != 0) begin
                        mon_p.d = '0;
                        mon_p.s = 9'(128 - acc % 128);
                        exp_q.push_back(mon_p);
                    end
                    acc = 0;
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [127:0] b, input logic l);
        bit ok;
        ok = 1'b0;
        bus.i_beat = b; bus.i_last = l; bus.i_valid = 1'b1;
        for (int c = 0; c < 300 && !ok; c++) begin
            if (rnd) bus.i_space = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(0, 143)) : 10'd512;
            @(negedge clk);
            ok = bus.o_ready;
            @(posedge clk); #1;
        end
        bus.i_valid = 1'b0; bus.i_last = 1'b0;
        if (!ok) begin
            n_cmp++; n_bad++;
            $display("FAIL put_timeout: got o_ready=0 for 300 cycles expected acceptance");
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic chk_stats_bits(input string nm, input int exp_bits);
`ifdef ZVC_STATS_EN
        chk(nm, 256'(bus.o_bit_count), 256'(exp_bits));
`else
        chk(nm, 256'(bus.o_bit_count), 256'd0);
`endif
    endtask

    vec_t tbl[5];
    logic [127:0] b;
    int lat;

    initial begin
        tbl[0] = '{128'h0, 9'd16, 144'h0};
        tbl[1] = '{128'h01, 9'd24, {24'h000101, 120'h0}};
        tbl[2] = '{{128{1'b1}}, 9'd144, {144{1'b1}}};
        tbl[3] = '{{8'hAB, 120'h0}, 9'd24, {24'h8000AB, 120'h0}};
        tbl[4] = '{(128'h34 << 72) | (128'h12 << 24), 9'd32, {32'h0208_1234, 112'h0}};

        bus.i_beat = '0; bus.i_valid = 1'b0; bus.i_last = 1'b0; bus.i_space = 10'd512;
        rst = 1'b1;
        #1;
        chk("rst_ready", 256'(bus.o_ready), 256'd1);
        chk("rst_wen", 256'(bus.o_write_en), 256'd0);
        chk("rst_data", bus.o_data, 256'd0);
        chk("rst_size", 256'(bus.o_data_size), 256'd0);
        chk("rst_beats", 256'(bus.o_beat_count), 256'd0);
        chk("rst_bits", 256'(bus.o_bit_count), 256'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Two-beat tile: 16 + 24 bits, then an 88-bit pad
        log_q.delete();
        put(128'h0, 1'b0);
        put(128'h01, 1'b1);
        idle(8);
        chk("tile_nwr", 256'(log_q.size()), 256'd3);
        if (log_q.size() == 3) begin
            chk("tile_s0", 256'(log_q[0].s), 256'd16);
            chk("tile_s1", 256'(log_q[1].s), 256'd24);
            chk("tile_pad_size", 256'(log_q[2].s), 256'd88);
            chk("tile_pad_data", log_q[2].d, 256'd0);
            chk("tile_pad_ready", 256'(log_q[2].rdy), 256'd0);
        end
        chk_stats_bits("tile_bitcount", 128);

        // Single-beat vectors, constant expectations
        for (int i = 0; i < 5; i++) begin
            log_q.delete();
            put(tbl[i].b, 1'b0);
            lat = 0;
            while (log_q.size() == 0 && lat < 20) begin
                @(negedge clk); #1;
                lat++;
            end
            if (log_q.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL vec%0d_timeout: got no write expected size %0d", i, tbl[i].s);
            end else begin
                if (i == 0) chk("vec_latency", 256'(lat), 256'd2);
                chk($sformatf("vec%0d_size", i), 256'(log_q[0].s), 256'(tbl[i].s));
                chk($sformatf("vec%0d_data", i), log_q[0].d, {tbl[i].hi, 112'h0});
            end
            idle(2);
        end

        // 10 back-to-back full beats
        log_q.delete();
        bus.i_beat = '1; bus.i_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("b2b_ready", 256'(bus.o_ready), 256'd1);
            @(posedge clk); #1;
        end
        bus.i_valid = 1'b0;
        idle(5);
        chk("b2b_nwr", 256'(log_q.size()), 256'd10);
        if (log_q.size() == 10) chk("b2b_span", 256'(log_q[9].cyc - log_q[0].cyc), 256'd9);

        // Codeword held while it does not fit
        bus.i_space = 10'd20;
        put(128'h01, 1'b0);
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("hold_wen", 256'(bus.o_write_en), 256'd0);
            chk("hold_size", 256'(bus.o_data_size), 256'd24);
            chk("hold_data", bus.o_data, {24'h000101, 232'h0});
        end
        @(posedge clk); #1 bus.i_space = 10'd24;
        @(negedge clk);
        chk("space24_wen", 256'(bus.o_write_en), 256'd1);
        @(posedge clk); #1 bus.i_space = 10'd512;
        idle(3);

        // Reset while a 112-bit pad is stuck in PAD
        do_reset();
        bus.i_space = 10'd100;
        put(128'h0, 1'b1);
        repeat (4) @(negedge clk);
        chk("pad_ready", 256'(bus.o_ready), 256'd0);
        chk("pad_wen", 256'(bus.o_write_en), 256'd0);
        chk("pad_size", 256'(bus.o_data_size), 256'd112);
        @(posedge clk); #2 rst = 1'b1;
        #1;
        chk("rstpad_wen", 256'(bus.o_write_en), 256'd0);
        chk("rstpad_size", 256'(bus.o_data_size), 256'd0);
        chk("rstpad_data", bus.o_data, 256'd0);
        chk("rstpad_ready", 256'(bus.o_ready), 256'd1);
        @(negedge clk);
        @(posedge clk); #1 rst = 1'b0;
        bus.i_space = 10'd512;
        log_q.delete();
        put({16'h0, {14{8'h5A}}}, 1'b1);
        idle(8);
        chk("aligned_nwr", 256'(log_q.size()), 256'd1);
        if (log_q.size() == 1) chk("aligned_size", 256'(log_q[0].s), 256'd128);
        chk_stats_bits("aligned_bitcount", 128);

        // Random beats, sparsity and i_space against the model
        do_reset();
        rnd = 1'b1;
        for (int n = 0; n < 300; n++) begin
            for (int k = 0; k < 16; k++)
                b[8*k +: 8] = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
            put(b, ($urandom_range(0, 7) == 0));
            for (int g = $urandom_range(0, 2); g > 0; g--) begin
                bus.i_space = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(0, 143)) : 10'd512;
                @(posedge clk); #1;
            end
        end
        rnd = 1'b0;
        bus.i_space = 10'd512;
        idle(20);
        chk("rand_drained", 256'(exp_q.size()), 256'd0);
`ifdef ZVC_STATS_EN
        chk("rand_beats", 256'(bus.o_beat_count), 256'(m_beats));
`else
        chk("rand_beats", 256'(bus.o_beat_count), 256'd0);
`endif
        chk_stats_bits("rand_bits", m_bits);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
